// File: rtl/fall_pkg.sv
// Shared types and constants for the accelerometer fall detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fall_pkg;

  // Detection sequence: wait for free fall, wait for impact, settle, check tilt.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IMPACT = 2'd1,
    HOLD   = 2'd2,
    CHECK  = 2'd3
  } fall_state_t;

  // Bit positions inside the stage progress vector.
  localparam int STG_FF     = 0;
  localparam int STG_IMPACT = 1;
  localparam int STG_CONF   = 2;

  // Reset-time threshold suggestions for the controller (raw sensor LSBs).
  localparam int unsigned DEF_THR_FF   = 32'd10000;
  localparam int unsigned DEF_THR_SVM  = 32'd580000000;
  localparam int unsigned DEF_THR_TILT = 32'd10000;

endpackage

// File: rtl/fall_svm.sv
// Registers one 3-axis sample: az, |ax|, |ay| and squared magnitude ax^2+ay^2+az^2.
// Latency: 1 clk from load to registered outputs.
// Backpressure: none; every load strobe overwrites the held sample.
//
// Ports: clk/reset (sync, active-low); load captures ax/ay/az;
//        az_q signed az, abs_ax/abs_ay DW+1-bit magnitudes, svm 2*DW-bit sum of squares.
module fall_svm #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic signed [DW-1:0] ax,
  input  logic signed [DW-1:0] ay,
  input  logic signed [DW-1:0] az,
  output logic signed [DW-1:0] az_q,
  output logic [DW:0]          abs_ax,
  output logic [DW:0]          abs_ay,
  output logic [2*DW-1:0]      svm
);

  localparam int PW = 2 * DW;

  // One extra bit so that |-2^(DW-1)| = 2^(DW-1) is representable.
  function automatic logic [DW:0] mag(input logic signed [DW-1:0] v);
    logic signed [DW:0] e;
    e = {v[DW-1], v};
    return e[DW] ? $unsigned(-e) : $unsigned(e);
  endfunction

  logic signed [PW-1:0] ax_w, ay_w, az_w;
  logic signed [PW-1:0] sq_x, sq_y, sq_z;
  logic [PW-1:0]        svm_d;

  assign ax_w = PW'(ax);
  assign ay_w = PW'(ay);
  assign az_w = PW'(az);

  // Each square is at most 2^(2*DW-2), so three of them fit in 2*DW unsigned bits.
  assign sq_x  = ax_w * ax_w;
  assign sq_y  = ay_w * ay_w;
  assign sq_z  = az_w * az_w;
  assign svm_d = $unsigned(sq_x) + $unsigned(sq_y) + $unsigned(sq_z);

  always_ff @(posedge clk) begin
    if (!reset) begin
      az_q   <= '0;
      abs_ax <= '0;
      abs_ay <= '0;
      svm    <= '0;
    end else if (load) begin
      az_q   <= az;
      abs_ax <= mag(ax);
      abs_ay <= mag(ay);
      svm    <= svm_d;
    end
  end

endmodule

// File: rtl/fall_detect_fsm.sv
// Fall detector: free-fall -> impact -> settle -> tilt check, latched alarm, fall counter.
// Latency: tick at cycle T -> sample registered at T+1 edge -> FSM/outputs updated at T+2 edge.
// Backpressure: none; samples arriving on ticks are consumed unconditionally.
//
// Ports: clk, reset (sync, active-low), enable, ext_tick, ax/ay/az signed samples,
//        thr_ff (signed), thr_svm (unsigned 2*DW), thr_tilt (unsigned), alarm_ack;
//        stage progress flags, alarm, fall_cnt (saturating), busy (state != IDLE).
module fall_detect_fsm
  import fall_pkg::*;
#(
  parameter int DW           = 16,
  parameter int SAMPLE_DIV   = 1048576,
  parameter int USE_EXT_TICK = 0,
  parameter int FF_MIN       = 2,
  parameter int IMPACT_WIN   = 8,
  parameter int HOLD_TICKS   = 94,
  parameter int CW           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 ext_tick,
  input  logic signed [DW-1:0] ax,
  input  logic signed [DW-1:0] ay,
  input  logic signed [DW-1:0] az,
  input  logic signed [DW-1:0] thr_ff,
  input  logic [2*DW-1:0]      thr_svm,
  input  logic [DW-1:0]        thr_tilt,
  input  logic                 alarm_ack,
  output logic [2:0]           stage,
  output logic                 alarm,
  output logic [CW-1:0]        fall_cnt,
  output logic                 busy
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int FFW   = $clog2(FF_MIN + 1);
  localparam int WINW  = $clog2(IMPACT_WIN + 1);
  localparam int HW    = $clog2(HOLD_TICKS + 1);

  // ---------------------------------------------------------------- sample tick
  logic [DIV_W-1:0] div_cnt;
  logic             div_term;
  logic             tick;
  logic             eval_q;

  assign div_term = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  // Divider is parked at 0 while disabled so re-enable starts a full period.
  always_ff @(posedge clk) begin
    if (!reset || !enable || div_term) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = enable & ((USE_EXT_TICK != 0) ? ext_tick : div_term);

  // Decisions run one cycle after the tick, once the sample registers are loaded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      eval_q <= 1'b0;
    end else begin
      eval_q <= tick;
    end
  end

  // ---------------------------------------------------------------- sample path
  logic signed [DW-1:0] az_q;
  logic [DW:0]          abs_ax, abs_ay;
  logic [2*DW-1:0]      svm_q;

  fall_svm #(.DW(DW)) u_svm (
    .clk    (clk),
    .reset  (reset),
    .load   (tick),
    .ax     (ax),
    .ay     (ay),
    .az     (az),
    .az_q   (az_q),
    .abs_ax (abs_ax),
    .abs_ay (abs_ay),
    .svm    (svm_q)
  );

  // ---------------------------------------------------------------- FSM state
  fall_state_t   state, state_nxt;
  logic [FFW-1:0]  ff_cnt, ff_nxt;
  logic [WINW-1:0] win_cnt, win_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [2:0]      stage_q, stage_nxt;
  logic            alarm_q, alarm_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            confirm;
  logic            az_ff;
  logic            tilted;

  // 0 < az < thr_ff, all signed.
  assign az_ff  = !az_q[DW-1] && (az_q != '0) && (az_q < thr_ff);
  assign tilted = (abs_ax > {1'b0, thr_tilt}) || (abs_ay > {1'b0, thr_tilt});

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ff_cnt   <= '0;
      win_cnt  <= '0;
      hold_cnt <= '0;
      stage_q  <= '0;
      alarm_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      ff_cnt   <= ff_nxt;
      win_cnt  <= win_nxt;
      hold_cnt <= hold_nxt;
      stage_q  <= stage_nxt;
      alarm_q  <= alarm_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ff_nxt    = ff_cnt;
    win_nxt   = win_cnt;
    hold_nxt  = hold_cnt;
    stage_nxt = stage_q;
    confirm   = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      ff_nxt    = '0;
      win_nxt   = '0;
      hold_nxt  = '0;
      stage_nxt = '0;
    end else if (eval_q) begin
      unique case (state)
        IDLE: begin
          if (az_ff) begin
            ff_nxt = ff_cnt + FFW'(1);
            if (ff_nxt == FFW'(FF_MIN)) begin
              state_nxt         = IMPACT;
              ff_nxt            = '0;
              win_nxt           = '0;
              stage_nxt         = '0;
              stage_nxt[STG_FF] = 1'b1;
            end
          end else begin
            ff_nxt = '0;
          end
        end
        IMPACT: begin
          if (svm_q > thr_svm) begin
            state_nxt             = HOLD;
            win_nxt               = '0;
            hold_nxt              = '0;
            stage_nxt[STG_IMPACT] = 1'b1;
          end else begin
            win_nxt = win_cnt + WINW'(1);
            if (win_nxt == WINW'(IMPACT_WIN)) begin
              state_nxt = IDLE;
              win_nxt   = '0;
              stage_nxt = '0;
            end
          end
        end
        HOLD: begin
          hold_nxt = hold_cnt + HW'(1);
          if (hold_nxt == HW'(HOLD_TICKS)) begin
            state_nxt = CHECK;
            hold_nxt  = '0;
          end
        end
        CHECK: begin
          state_nxt = IDLE;
          if (tilted) begin
            stage_nxt[STG_CONF] = 1'b1;
            confirm             = 1'b1;
          end else begin
            stage_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          stage_nxt = '0;
        end
      endcase
    end

    // A confirm in the same cycle as an ack wins, so the new fall is not lost.
    alarm_nxt = confirm | (alarm_q & ~alarm_ack);
    cnt_nxt   = (confirm && (cnt_q != {CW{1'b1}})) ? cnt_q + CW'(1) : cnt_q;
  end

  always_comb begin
    stage    = stage_q;
    alarm    = alarm_q;
    fall_cnt = cnt_q;
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_fall_detect_fsm.sv
module tb_fall_detect_fsm;
  import fall_pkg::*;

  localparam int DW         = 16;
  localparam int FF_MIN     = 2;
  localparam int IMPACT_WIN = 4;
  localparam int HOLD_TICKS = 3;
  localparam int CW         = 8;
  localparam int CNT_MAX    = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, ext_tick = 1'b0, alarm_ack = 1'b0;
  logic signed [DW-1:0] ax = '0, ay = '0, az = '0, thr_ff;
  logic [2*DW-1:0] thr_svm;
  logic [DW-1:0]   thr_tilt;
  logic [2:0]      stage, div_stage;
  logic            alarm, busy, div_alarm, div_busy;
  logic [CW-1:0]   fall_cnt, div_fall_cnt;

  always #10 clk = ~clk;

  fall_detect_fsm #(.DW(DW), .SAMPLE_DIV(4), .USE_EXT_TICK(1), .FF_MIN(FF_MIN),
                    .IMPACT_WIN(IMPACT_WIN), .HOLD_TICKS(HOLD_TICKS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ext_tick(ext_tick),
    .ax(ax), .ay(ay), .az(az), .thr_ff(thr_ff), .thr_svm(thr_svm), .thr_tilt(thr_tilt),
    .alarm_ack(alarm_ack), .stage(stage), .alarm(alarm), .fall_cnt(fall_cnt), .busy(busy));

  // Second instance exercises the internal divider (tick every 3 clocks).
  fall_detect_fsm #(.DW(DW), .SAMPLE_DIV(3), .USE_EXT_TICK(0), .FF_MIN(FF_MIN),
                    .IMPACT_WIN(IMPACT_WIN), .HOLD_TICKS(HOLD_TICKS), .CW(CW)) u_div (
    .clk(clk), .reset(reset), .enable(enable), .ext_tick(ext_tick),
    .ax(ax), .ay(ay), .az(az), .thr_ff(thr_ff), .thr_svm(thr_svm), .thr_tilt(thr_tilt),
    .alarm_ack(alarm_ack), .stage(div_stage), .alarm(div_alarm), .fall_cnt(div_fall_cnt),
    .busy(div_busy));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 waiting for free fall, 1 impact window,
  // 2 settling, 3 tilt check. Magnitudes in full-width integers.
  int         m_phase, m_ff, m_win, m_hold, m_falls;
  logic [2:0] m_stage;
  bit         m_alarm;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear_seq();
    m_phase = 0; m_ff = 0; m_win = 0; m_hold = 0; m_stage = 3'b000;
  endtask

  task automatic model_reset();
    model_clear_seq();
    m_alarm = 1'b0; m_falls = 0;
  endtask

  task automatic model_eval(input int x, input int y, input int z, input bit ack);
    longint mag2;
    bit     confirmed;
    mag2      = longint'(x) * x + longint'(y) * y + longint'(z) * z;
    confirmed = 1'b0;
    case (m_phase)
      0: begin
        if (z > 0 && z < int'(thr_ff)) m_ff++;
        else m_ff = 0;
        if (m_ff == FF_MIN) begin
          m_phase = 1; m_ff = 0; m_win = 0; m_stage = 3'b001;
        end
      end
      1: begin
        if (mag2 > longint'(thr_svm)) begin
          m_phase = 2; m_hold = 0; m_stage[1] = 1'b1;
        end else begin
          m_win++;
          if (m_win == IMPACT_WIN) begin m_phase = 0; m_stage = 3'b000; end
        end
      end
      2: begin
        m_hold++;
        if (m_hold == HOLD_TICKS) m_phase = 3;
      end
      default: begin
        if (iabs(x) > int'(thr_tilt) || iabs(y) > int'(thr_tilt)) begin
          confirmed = 1'b1; m_stage[2] = 1'b1;
          if (m_falls < CNT_MAX) m_falls++;
        end else begin
          m_stage = 3'b000;
        end
        m_phase = 0;
      end
    endcase
    m_alarm = confirmed | (m_alarm & !ack);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".stage"}, stage, m_stage);
    chk({tag, ".alarm"}, alarm, m_alarm);
    chk({tag, ".fall_cnt"}, fall_cnt, m_falls);
    chk({tag, ".busy"}, busy, (m_phase != 0));
  endtask

  // One ext_tick sample; outputs must not move until the second edge.
  task automatic do_tick(input int x, input int y, input int z, input bit ack);
    ax = DW'(x); ay = DW'(y); az = DW'(z);
    ext_tick = 1'b1; alarm_ack = 1'b0;
    @(negedge clk);
    ext_tick = 1'b0; alarm_ack = ack;
    cmp_model("pre");
    @(negedge clk);
    alarm_ack = 1'b0;
    model_eval(x, y, z, ack);
    cmp_model("post");
  endtask

  task automatic do_fall(input int cx, input int cy, input bit ack);
    repeat (FF_MIN) do_tick(0, 0, 5000, 1'b0);
    do_tick(20000, 20000, 20000, 1'b0);
    repeat (HOLD_TICKS) do_tick(0, 0, 16000, 1'b0);
    do_tick(cx, cy, 16000, ack);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset();
  endtask

  function automatic int rsign(input int v);
    return ($urandom_range(0, 1) != 0) ? v : -v;
  endfunction

  function automatic int rfull();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, z;
    bit k;
    thr_ff   = DW'(DEF_THR_FF);
    thr_svm  = 32'(DEF_THR_SVM);
    thr_tilt = DW'(DEF_THR_TILT);
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stage", stage, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_cnt", fall_cnt, 0);
    chk("rst_busy", busy, 0);

    // Internal divider: ticks on edges 2,5 after release; FSM sees them at edges 4,7
    az = 16'sd5000; enable = 1'b1; reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 6) chk("div_before", div_stage, 0);
      if (e == 7) chk("div_ff", div_stage, 1);
    end

    // Confirmed fall
    apply_reset();
    do_fall(15000, 0, 1'b0);
    chk("tp1_stage", stage, 3'b111);
    chk("tp1_alarm", alarm, 1);
    chk("tp1_cnt", fall_cnt, 1);

    // No tilt at check
    apply_reset();
    do_fall(2000, 2000, 1'b0);
    chk("tp2_stage", stage, 3'b000);
    chk("tp2_alarm", alarm, 0);
    chk("tp2_cnt", fall_cnt, 0);

    // Impact window expires
    apply_reset();
    repeat (FF_MIN) do_tick(0, 0, 5000, 1'b0);
    chk("win_start", stage, 3'b001);
    repeat (IMPACT_WIN) do_tick(10000, 10000, 10000, 1'b0);
    chk("win_stage", stage, 3'b000);
    chk("win_busy", busy, 0);

    // Non-positive az breaks the free-fall run
    apply_reset();
    do_tick(0, 0, 5000, 1'b0);
    do_tick(0, 0, -100, 1'b0);
    do_tick(0, 0, 5000, 1'b0);
    chk("ffbrk_stage", stage, 3'b000);

    // Ack coincident with confirm, then a lone ack
    apply_reset();
    do_fall(15000, 0, 1'b1);
    chk("ackc_alarm", alarm, 1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    m_alarm = 1'b0;
    cmp_model("ack");
    chk("ack_cnt", fall_cnt, 1);

    // ext_tick held two cycles = two ticks
    apply_reset();
    ax = '0; ay = '0; az = 16'sd5000; ext_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ext_tick = 1'b0;
    @(negedge clk);
    model_eval(0, 0, 5000, 1'b0);
    model_eval(0, 0, 5000, 1'b0);
    cmp_model("ext2");
    chk("ext2_stage", stage, 3'b001);

    // |-32768| exceeds 32767; |32767| does not
    apply_reset();
    thr_tilt = 16'd32767;
    do_fall(-32768, 0, 1'b0);
    chk("absmin_stage", stage, 3'b111);
    do_fall(32767, -32767, 1'b0);
    chk("absmax_stage", stage, 3'b000);
    thr_tilt = DW'(DEF_THR_TILT);

    // Disable during IMPACT: sequence dropped, alarm kept
    repeat (FF_MIN) do_tick(0, 0, 5000, 1'b0);
    chk("en_pre", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    model_clear_seq();
    cmp_model("en");
    chk("en_alarm", alarm, 1);
    do_tick(0, 0, 5000, 1'b0);
    chk("en_ffcnt", stage, 3'b000);

    // Randomized sequences against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        thr_tilt = DW'($urandom_range(5000, 20000));
        thr_ff   = DW'($urandom_range(3000, 15000));
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          x = rsign($urandom_range(0, 3000)); y = rsign($urandom_range(0, 3000));
          z = $urandom_range(1, 16000);
        end
        4, 5: begin
          x = rsign($urandom_range(12000, 32767)); y = rsign($urandom_range(12000, 32767));
          z = rsign($urandom_range(12000, 32767));
        end
        6, 7: begin
          x = rsign($urandom_range(4000, 32768)); y = rsign($urandom_range(0, 20000));
          z = $urandom_range(0, 16000);
        end
        8: begin x = rfull(); y = rfull(); z = rfull(); end
        default: begin x = 0; y = 0; z = -$urandom_range(0, 32768); end
      endcase
      if (x > 32767) x = 32767;
      k = ($urandom_range(0, 7) == 0);
      do_tick(x, y, z, k);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    thr_ff   = DW'(DEF_THR_FF);
    thr_tilt = DW'(DEF_THR_TILT);

    // Counter saturation
    apply_reset();
    repeat (256) do_fall(15000, 0, 1'b0);
    chk("sat_cnt", fall_cnt, 255);

    // Reset during HOLD
    repeat (FF_MIN) do_tick(0, 0, 5000, 1'b0);
    do_tick(20000, 20000, 20000, 1'b0);
    do_tick(0, 0, 16000, 1'b0);
    chk("hold_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("hrst_stage", stage, 0);
    chk("hrst_alarm", alarm, 0);
    chk("hrst_cnt", fall_cnt, 0);
    chk("hrst_busy", busy, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fall_detect_fsm.md
# fall_detect_fsm

Parametrised accelerometer fall detector: successor to the fixed-threshold Human_Sensor fall tester. It consumes signed 3-axis acceleration samples from the IMU reader and runs a free-fall -> impact -> post-impact-tilt sequence on a programmable sample tick. It raises a latched, acknowledgeable alarm and keeps a fall counter for the controller. Thresholds are run-time ports, not constants; window lengths are parameters.

## Interface
- DW, 16: sample width (signed)
- SAMPLE_DIV, 1048576: clk cycles per internal sample tick (≥2)
- USE_EXT_TICK, 0: 1 = use ext_tick instead of internal divider
- FF_MIN, 2: consecutive free-fall ticks required
- IMPACT_WIN, 8: ticks allowed between free-fall and impact
- HOLD_TICKS, 94: ticks of settling before tilt check (~2 s at 47 Hz)
- CW, 8: fall counter width
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low
- enable  in  1  detection enable
- ext_tick  in  1  external sample strobe (USE_EXT_TICK=1 only)
- ax, ay, az  in  DW each  signed acceleration
- thr_ff  in  DW  signed free-fall az threshold
- thr_svm  in  2*DW  unsigned squared-magnitude impact threshold
- thr_tilt  in  DW  unsigned tilt threshold on |ax|, |ay|
- alarm_ack  in  1  clears alarm
- stage  out  3  progress flags [0]=free-fall, [1]=impact, [2]=confirmed
- alarm  out  1  latched fall alarm
- fall_cnt  out  CW  saturating count of confirmed falls
- busy  out  1  FSM not in IDLE

## Operation
- Tick: internal counter 0..SAMPLE_DIV-1, tick on terminal value; else ext_tick. On tick, ax/ay/az are registered; svm = ax²+ay²+az² is registered in the same cycle (2*DW unsigned, cannot overflow). All FSM decisions occur on the following clk cycle (eval).
- IDLE: on eval, if 0 < az < thr_ff, ff_cnt++, else ff_cnt=0. ff_cnt reaching FF_MIN -> IMPACT, stage[0]=1.
- IMPACT: on eval, svm > thr_svm -> HOLD, stage[1]=1, clear window counter; else window++; window reaching IMPACT_WIN -> IDLE, stage=0.
- HOLD: counts HOLD_TICKS evals -> CHECK.
- CHECK: on eval, |ax|>thr_tilt or |ay|>thr_tilt -> stage[2]=1, alarm=1, fall_cnt++ (saturates at 2^CW-1), -> IDLE; else -> IDLE, stage=0.
- stage[2:0] remains held after confirmation until the next free-fall entry, which loads stage=3'b001.
- |x| of -2^(DW-1) is 2^(DW-1) (DW+1-bit unsigned compare).
- alarm cleared by alarm_ack; simultaneous confirm and ack: alarm stays 1.
- enable=0: FSM to IDLE, ff_cnt/window/hold counters and stage cleared, tick divider held at 0; alarm and fall_cnt retained.
- Thresholds sampled on eval; changes mid-sequence take effect at next eval.

## Timing
- Reset (reset=0 at clk edge): state IDLE, all counters 0, stage=0, alarm=0, fall_cnt=0, busy=0; applies mid-sequence, no partial alarm.
- Tick at cycle T: samples/svm registered at T+1 edge; FSM transition and outputs visible after T+2 edge.
- Minimum confirmation: FF_MIN + 1 + HOLD_TICKS + 1 ticks from first free-fall sample.
- ext_tick high for N consecutive cycles counts as N ticks.

## Structure
- Package fall_pkg: state enum (IDLE, IMPACT, HOLD, CHECK), stage bit indices, default thresholds (thr_ff 10000, thr_svm 580000000, thr_tilt 10000).
- Sub-module fall_svm: registered sum-of-squares with abs outputs for ax/ay.

## Test plan
(USE_EXT_TICK=1, FF_MIN=2, IMPACT_WIN=4, HOLD_TICKS=3, default thresholds)
- az=5000 ×2 ticks, then ax=ay=az=20000 (svm 1.2e9), hold ×3, then ax=15000 -> stage=111, alarm=1, fall_cnt=1, two cycles after final tick.
- Same, but check tick ax=ay=2000 -> stage=000, alarm=0, fall_cnt=0.
- Free-fall ×2, then svm=3e8 for 4 ticks -> back to IDLE, stage=000 after 4th eval.
- az=5000, az=-100, az=5000 -> stage[0] never set (ff_cnt reset by az≤0).
- alarm_ack in the same cycle as a confirm -> alarm=1; ack later -> alarm=0, fall_cnt unchanged; 256 falls with CW=8 -> fall_cnt=255.
- reset=0 during HOLD -> all outputs 0 next cycle; enable=0 during IMPACT -> IDLE, stage=000, alarm retained.
